// File: rtl/tiny_proc_pkg.sv
// Shared definitions for the tiny processor and its program loader:
// data/instruction width, instruction memory depth, a constant-safe
// ceiling-log2 helper and the loader state encoding.
package tiny_proc_pkg;

  localparam int INST_W  = 8;
  localparam int IMEM_SZ = 16;

  // Ceiling log2, usable in parameter expressions (clog2(1) = 0)
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  typedef enum logic [2:0] {
    SETTLE = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    RUN    = 3'd3,
    ERROR  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a delay
// flop so that rising and falling edges of the synchronized level can be
// detected without reading the metastable first stage.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // Shift the pin through the synchronizer chain and keep one delayed copy of the settled level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      dly_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~dly_r;
  assign fall  = ~sync_r[SYNC_STAGES-1] & dly_r;

endmodule

// File: rtl/imem_loader.sv
// Program loader in front of the processor core. Receives IMEM_SZ bytes
// plus an XOR checksum over a strobed byte bus, writes the bytes into
// instruction memory, holds the core while loading and releases it with a
// one-cycle restart pulse once the checksum matches.
module imem_loader #(
  parameter int  INST_W      = tiny_proc_pkg::INST_W,
  parameter int  IMEM_SZ     = tiny_proc_pkg::IMEM_SZ,
  parameter int  SYNC_STAGES = 2,
  localparam int ADDR_W      = tiny_proc_pkg::clog2(IMEM_SZ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req_in,
  input  logic              strobe_in,
  input  logic [INST_W-1:0] data_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [INST_W-1:0] wr_data_out,
  output logic              core_run_out,
  output logic              core_restart_out,
  output logic              busy_out,
  output logic              err_out
);

  import tiny_proc_pkg::*;

  // Settle counter must reach SYNC_STAGES+1 so the request level is trustworthy
  localparam int                SETTLE_W    = clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0]   ADDR_LAST   = ADDR_W'(IMEM_SZ - 1);

  loader_state_e       state_r;
  logic [SETTLE_W-1:0] settle_cnt_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic [INST_W-1:0]   csum_r;

  logic req_level_s;
  logic req_rise_s;
  logic req_fall_s;
  logic stb_level_s;
  logic stb_rise_s;
  logic stb_fall_s;
  logic unused_ok_s;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (load_req_in),
    .level (req_level_s),
    .rise  (req_rise_s),
    .fall  (req_fall_s)
  );

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (strobe_in),
    .level (stb_level_s),
    .rise  (stb_rise_s),
    .fall  (stb_fall_s)
  );

  // Only the strobe rising edge matters; its level and falling edge are intentionally dropped
  assign unused_ok_s = &{1'b0, stb_level_s, stb_fall_s};

  // Loader FSM with settle counter, address/checksum registers and registered core-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= SETTLE;
      settle_cnt_r     <= '0;
      cnt_r            <= '0;
      csum_r           <= '0;
      wr_en_out        <= 1'b0;
      wr_addr_out      <= '0;
      wr_data_out      <= '0;
      core_run_out     <= 1'b0;
      core_restart_out <= 1'b0;
      busy_out         <= 1'b0;
      err_out          <= 1'b0;
    end else begin
      wr_en_out        <= 1'b0;
      core_restart_out <= 1'b0;
      case (state_r)
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            if (req_level_s) begin
              state_r  <= LOAD;
              cnt_r    <= '0;
              csum_r   <= '0;
              busy_out <= 1'b1;
            end else begin
              state_r          <= RUN;
              core_run_out     <= 1'b1;
              core_restart_out <= 1'b1;
            end
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
          end
        end

        LOAD: begin
          if (req_fall_s) begin
            // Abort wins over a coincident strobe; bytes already written stay
            state_r  <= ERROR;
            busy_out <= 1'b0;
            err_out  <= 1'b1;
          end else if (stb_rise_s) begin
            wr_en_out   <= 1'b1;
            wr_addr_out <= cnt_r;
            wr_data_out <= data_in;
            csum_r      <= csum_r ^ data_in;
            if (cnt_r == ADDR_LAST) begin
              state_r <= CHECK;
            end else begin
              cnt_r <= cnt_r + ADDR_W'(1);
            end
          end else begin
            state_r <= LOAD;
          end
        end

        CHECK: begin
          if (req_fall_s) begin
            state_r  <= ERROR;
            busy_out <= 1'b0;
            err_out  <= 1'b1;
          end else if (stb_rise_s) begin
            busy_out <= 1'b0;
            if (data_in == csum_r) begin
              state_r          <= RUN;
              core_run_out     <= 1'b1;
              core_restart_out <= 1'b1;
            end else begin
              state_r <= ERROR;
              err_out <= 1'b1;
            end
          end else begin
            state_r <= CHECK;
          end
        end

        RUN: begin
          // Strobes are ignored here; a new request edge starts a fresh load
          if (req_rise_s) begin
            state_r      <= LOAD;
            cnt_r        <= '0;
            csum_r       <= '0;
            core_run_out <= 1'b0;
            busy_out     <= 1'b1;
          end else begin
            state_r <= RUN;
          end
        end

        ERROR: begin
          if (req_rise_s) begin
            state_r  <= LOAD;
            cnt_r    <= '0;
            csum_r   <= '0;
            err_out  <= 1'b0;
            busy_out <= 1'b1;
          end else begin
            state_r <= ERROR;
          end
        end

        default: begin
          // Illegal encoding: hold the core and restart the settle sequence
          state_r          <= SETTLE;
          settle_cnt_r     <= '0;
          cnt_r            <= '0;
          csum_r           <= '0;
          core_run_out     <= 1'b0;
          busy_out         <= 1'b0;
          err_out          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader. A host model drives bytes
// within the pin timing rules; expected writes and end states come from a
// simple program/checksum model (XOR fold over the program bytes).
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic       load_req_in;
  logic       strobe_in;
  logic [7:0] data_in;
  logic       wr_en_out;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic       core_run_out;
  logic       core_restart_out;
  logic       busy_out;
  logic       err_out;

  int vectors     = 0;
  int miscompares = 0;
  int rst_pulses  = 0;

  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  logic [7:0]  prog[16];

  imem_loader #(
    .INST_W      (8),
    .IMEM_SZ     (16),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_req_in      (load_req_in),
    .strobe_in        (strobe_in),
    .data_in          (data_in),
    .wr_en_out        (wr_en_out),
    .wr_addr_out      (wr_addr_out),
    .wr_data_out      (wr_data_out),
    .core_run_out     (core_run_out),
    .core_restart_out (core_restart_out),
    .busy_out         (busy_out),
    .err_out          (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every imem write and restart pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_en_out === 1'b1) obs_q.push_back({wr_addr_out, wr_data_out});
    if (core_restart_out === 1'b1) rst_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor_fold();
    logic [7:0] acc;
    acc = 8'h00;
    foreach (prog[i]) acc = acc ^ prog[i];
    return acc;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #3 data_in = b;
    strobe_in = 1'b1;
    repeat (SYNC + 1 + $urandom_range(0, 2)) @(posedge clk);
    #3 strobe_in = 1'b0;
    repeat (SYNC + 1 + $urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic req_toggle();
    @(posedge clk);
    #3 load_req_in = 1'b0;
    repeat (6) @(posedge clk);
    #3 load_req_in = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Full program load from a fresh LOAD entry; checks the final outcome
  task automatic load_and_check(input string tag, input logic [7:0] cs);
    logic good;
    good = (cs == xor_fold());
    obs_q.delete();
    exp_q.delete();
    rst_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(prog[i]);
      exp_q.push_back({4'(i), prog[i]});
    end
    #1 check({tag, "_busy_check"}, busy_out, 1'b1);
    send_byte(cs);
    #1;
    check_writes(tag);
    check({tag, "_run"}, core_run_out, good);
    check({tag, "_err"}, err_out, !good);
    check({tag, "_busy"}, busy_out, 1'b0);
    check({tag, "_restarts"}, rst_pulses, good ? 1 : 0);
  endtask

  initial begin
    rst_n       = 1'b1;
    load_req_in = 1'b0;
    strobe_in   = 1'b0;
    data_in     = 8'h00;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", wr_en_out, 1'b0);
    check("rst_addr", wr_addr_out, 4'h0);
    check("rst_data", wr_data_out, 8'h00);
    check("rst_run", core_run_out, 1'b0);
    check("rst_restart", core_restart_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_err", err_out, 1'b0);
    repeat (3) @(posedge clk);

    // No request: restart pulse exactly SYNC+2 cycles after release
    @(negedge clk);
    rst_pulses = 0;
    rst_n = 1'b1;
    for (int k = 1; k <= SYNC + 4; k++) begin
      @(posedge clk);
      #1 check($sformatf("norq_restart_c%0d", k), core_restart_out, (k == SYNC + 2));
    end
    check("norq_run", core_run_out, 1'b1);
    check("norq_pulses", rst_pulses, 1);
    check("norq_writes", obs_q.size(), 0);

    // Good load: bytes 0x00..0x0F, checksum 0x00
    @(posedge clk);
    #3 load_req_in = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("good_busy", busy_out, 1'b1);
    check("good_run_low", core_run_out, 1'b0);
    for (int i = 0; i < 16; i++) prog[i] = 8'(i);
    load_and_check("good", 8'h00);

    // Bad checksum, then recovery with 0x1B x 16
    req_toggle();
    load_and_check("badcs", 8'h01);
    req_toggle();
    for (int i = 0; i < 16; i++) prog[i] = 8'h1B;
    load_and_check("recover", 8'h00);

    // Randomized programs with random good/bad checksums
    for (int r = 0; r < 4; r++) begin
      logic [7:0] cs;
      req_toggle();
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
      cs = xor_fold();
      if ($urandom_range(0, 1) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      load_and_check($sformatf("rand%0d", r), cs);
    end

    // Abort: req drops together with the 6th strobe
    req_toggle();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      prog[i] = 8'($urandom_range(0, 255));
      send_byte(prog[i]);
      exp_q.push_back({4'(i), prog[i]});
    end
    @(posedge clk);
    #3 data_in = 8'hA5;
    strobe_in   = 1'b1;
    load_req_in = 1'b0;
    repeat (SYNC + 4) @(posedge clk);
    #3 strobe_in = 1'b0;
    repeat (SYNC + 4) @(posedge clk);
    #1;
    check_writes("abort");
    check("abort_err", err_out, 1'b1);
    check("abort_busy", busy_out, 1'b0);
    check("abort_run", core_run_out, 1'b0);

    // Reload from RUN: get to RUN, strobes there are ignored, req rise restarts a load
    @(posedge clk);
    #3 load_req_in = 1'b1;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    load_and_check("torun", xor_fold());
    send_byte(8'h5A);
    @(posedge clk);
    #3 load_req_in = 1'b0;
    repeat (6) @(posedge clk);
    send_byte(8'hC3);
    #1 check("run_ignore_writes", obs_q.size(), 0);
    check("run_still_running", core_run_out, 1'b1);
    @(posedge clk);
    #3 load_req_in = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(posedge clk);
        #1 if (busy_out === 1'b1) seen = 1'b1;
      end
      check("reload_busy_seen", seen, 1'b1);
      check("reload_run_low", core_run_out, 1'b0);
    end

    // Reset in the middle of a load
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      prog[i] = 8'($urandom_range(1, 255));
      send_byte(prog[i]);
      exp_q.push_back({4'(i), prog[i]});
    end
    #1 check_writes("midrst");
    check("midrst_addr_before", wr_addr_out, 4'h7);
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en_out, 1'b0);
    check("midrst_addr", wr_addr_out, 4'h0);
    check("midrst_data", wr_data_out, 8'h00);
    check("midrst_run", core_run_out, 1'b0);
    check("midrst_restart", core_restart_out, 1'b0);
    check("midrst_busy", busy_out, 1'b0);
    check("midrst_err", err_out, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(posedge clk);
      #1 check($sformatf("settle_busy_c%0d", k), busy_out, (k == SYNC + 2));
      check($sformatf("settle_restart_c%0d", k), core_restart_out, 1'b0);
    end

    @(posedge clk);
    #3 load_req_in = 1'b0;
    repeat (6) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
